// File: rtl/osd_spi_sequencer.sv
// ---------------------------------------------------------------------------
// osd_spi_sequencer
//
// Core-side SPI master for the OSD overlay's SPI port. It lets core logic
// enable or disable the OSD, or write one OSD line, without the IO controller.
// One command is accepted at a time. It is framed with ss low and shifted out
// MSB first. Write-line commands then pull LINE_BYTES payload bytes through a
// valid/ready handshake.
//
// Parameters
//   CLK_DIV    : sck half-period in clk cycles (1..255)
//   LINE_BYTES : payload bytes per line-write command
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   req       in   command request, sampled only while busy=0
//   req_cmd   in   0=disable (0x40), 1=enable (0x41), 2=write line, 3=reserved
//   req_line  in   OSD line (0..7) for write line (command 0x20|line)
//   busy      out  high from request acceptance until the done cycle
//   done      out  single-cycle pulse at the end of a transaction
//   wr_data   in   payload byte
//   wr_valid  in   payload byte available
//   wr_ready  out  sequencer ready to take a payload byte
//   sck       out  SPI clock, idle low
//   ss        out  SPI select, active low, idle high
//   sdi       out  SPI data to the OSD
// ---------------------------------------------------------------------------
module osd_spi_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int LINE_BYTES = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [1:0] req_cmd,
  input  logic [2:0] req_line,
  output logic       busy,
  output logic       done,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       sck,
  output logic       ss,
  output logic       sdi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    FETCH = 3'd3,
    TAIL  = 3'd4,
    GAP   = 3'd5
  } state_t;

  // The divider counts down from CLK_DIV-1, so a phase lasts CLK_DIV cycles.
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [8:0] PAY_TOTAL = 9'(LINE_BYTES);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [8:0]  pay_cnt;
  logic [7:0]  shreg;
  logic        is_write;
  logic        gap_half;

  logic        div_end;
  logic        accept;
  logic        take_byte;
  logic        byte_end;
  logic        more_payload;
  logic        gap_exit;
  logic [7:0]  cmd_byte;

  assign div_end      = (div_cnt == 8'd0);
  assign accept       = (state == IDLE) && req && (req_cmd != 2'd3);
  assign take_byte    = (state == FETCH) && wr_valid;
  assign byte_end     = (bit_cnt == 3'd7);
  assign more_payload = is_write && (pay_cnt < PAY_TOTAL);
  // GAP spans two divider periods; gap_half marks the second one.
  assign gap_exit     = (state == GAP) && div_end && gap_half;

  // Command byte encoding for the OSD receiver.
  always_comb begin
    cmd_byte = 8'h00;
    case (req_cmd)
      2'd0:    cmd_byte = 8'h40;
      2'd1:    cmd_byte = 8'h41;
      2'd2:    cmd_byte = {5'b00100, req_line};
      default: cmd_byte = 8'h00;
    endcase
  end

  // State register. Asserting reset drops straight back to IDLE, which
  // deselects the OSD at once and aborts any partial byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: every timed phase waits for the divider to expire.
  // FETCH has no timeout and waits as long as the payload source stalls.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LOW;
      end
      LOW: begin
        if (div_end) state_nxt = HIGH;
      end
      HIGH: begin
        if (div_end) begin
          if (!byte_end)         state_nxt = LOW;
          else if (more_payload) state_nxt = FETCH;
          else                   state_nxt = TAIL;
        end
      end
      FETCH: begin
        if (take_byte) state_nxt = LOW;
      end
      TAIL: begin
        if (div_end) state_nxt = GAP;
      end
      GAP: begin
        if (gap_exit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: divider, bit and payload counters, shift register and the
  // done pulse. The divider reloads on every phase change and also at the
  // midpoint of GAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      pay_cnt  <= 9'd0;
      shreg    <= 8'd0;
      is_write <= 1'b0;
      gap_half <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= gap_exit;

      if ((state_nxt != state) || div_end) begin
        div_cnt <= DIV_LAST;
      end else begin
        div_cnt <= div_cnt - 8'd1;
      end

      if (accept) begin
        bit_cnt <= 3'd0;
      end else if ((state == HIGH) && div_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == IDLE) begin
        pay_cnt <= 9'd0;
      end else if (take_byte) begin
        pay_cnt <= pay_cnt + 9'd1;
      end

      // Shift on the falling sck edge so sdi settles a half period before
      // the next rising edge. At byte end the last bit is held.
      if (accept) begin
        shreg <= cmd_byte;
      end else if (take_byte) begin
        shreg <= wr_data;
      end else if ((state == HIGH) && div_end && !byte_end) begin
        shreg <= {shreg[6:0], 1'b0};
      end

      if (accept) begin
        is_write <= (req_cmd == 2'd2);
      end

      if (state != GAP) begin
        gap_half <= 1'b0;
      end else if (div_end) begin
        gap_half <= 1'b1;
      end
    end
  end

  // Moore outputs decoded from the state. sdi holds the current bit while
  // the frame is open and returns low once ss rises.
  always_comb begin
    sck      = 1'b0;
    ss       = 1'b1;
    sdi      = 1'b0;
    busy     = 1'b0;
    wr_ready = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      LOW: begin
        ss   = 1'b0;
        sdi  = shreg[7];
        busy = 1'b1;
      end
      HIGH: begin
        sck  = 1'b1;
        ss   = 1'b0;
        sdi  = shreg[7];
        busy = 1'b1;
      end
      FETCH: begin
        ss       = 1'b0;
        sdi      = shreg[7];
        busy     = 1'b1;
        wr_ready = 1'b1;
      end
      TAIL: begin
        ss   = 1'b0;
        sdi  = shreg[7];
        busy = 1'b1;
      end
      GAP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_osd_spi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_osd_spi_sequencer
//
// Self-checking bench for osd_spi_sequencer. A behavioural model builds the
// expected byte stream (command byte plus payload) and the expected frame
// timing from the command type. An SPI receiver inside the bench decodes sdi
// on each rising sck and compares the result with the model.
// ---------------------------------------------------------------------------
module tb_osd_spi_sequencer;

  localparam int C     = 4;
  localparam int LB    = 256;
  localparam int LIMIT = 40000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       req = 1'b0;
  logic [1:0] req_cmd = 2'd0;
  logic [2:0] req_line = 3'd0;
  logic       busy;
  logic       done;
  logic [7:0] wr_data = 8'd0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       sck;
  logic       ss;
  logic       sdi;

  int checks = 0;
  int failures = 0;

  logic [7:0] payload [LB];

  osd_spi_sequencer #(.CLK_DIV(C), .LINE_BYTES(LB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_line (req_line),
    .busy     (busy),
    .done     (done),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .sck      (sck),
    .ss       (ss),
    .sdi      (sdi)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report and count it on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Model: the command byte the OSD must receive for a request.
  function automatic logic [7:0] cmdByte(input int cmd, input int line);
    if (cmd == 0) return 8'h40;
    if (cmd == 1) return 8'h41;
    return 8'(32 + line);
  endfunction

  // Model: cycles ss stays low for a complete transaction.
  function automatic int ssLowCycles(input int cmd, input int stall);
    if (cmd == 2) return 16 * C + LB * (1 + 16 * C) + C + stall;
    return 17 * C;
  endfunction

  // Runs one transaction from request to done (or until a reset abort),
  // acting as the payload source and SPI receiver, and checks the result.
  task automatic applyStimulus(input int cmd, input int line, input int stall_at,
                               input int stall_len, input bit chained,
                               input bit poke_busy, input bit chain_next,
                               input int next_cmd, input int next_line,
                               input int rst_at);
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] acc;
    bit   is_wr, hs, sck_prev, aborted, done_busy;
    int   n, idx, nbits, busy_first, done_n, ss_low, busy_cnt, hs_cnt;
    int   stall_cnt, fetch_bad, sck_bad, hs_wait, exp_ss;

    is_wr = (cmd == 2);
    exp_q.delete();
    exp_q.push_back(cmdByte(cmd, line));
    if (is_wr) for (int i = 0; i < LB; i++) exp_q.push_back(payload[i]);
    exp_ss = ssLowCycles(cmd, stall_len);
    rx_q.delete();
    acc = 8'd0; nbits = 0; sck_prev = 1'b0; aborted = 1'b0; done_busy = 1'b0;
    idx = 0; busy_first = -1; done_n = -1; ss_low = 0; busy_cnt = 0;
    hs_cnt = 0; stall_cnt = 0; fetch_bad = 0; sck_bad = 0; hs_wait = 0;

    if (!chained) begin
      @(posedge clk); #1;
      req = 1'b1; req_cmd = 2'(cmd); req_line = 3'(line);
    end
    wr_data  = payload[0];
    wr_valid = is_wr;

    for (n = 0; n < LIMIT; n++) begin
      if (!(chained && n == 0)) @(negedge clk);
      hs = wr_valid && wr_ready;
      if (hs) hs_cnt++;
      if (!ss) ss_low++;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = n;
      end
      if (sck && !sck_prev) begin
        acc = {acc[6:0], sdi};
        nbits++;
        if (nbits == 8) begin
          rx_q.push_back(acc);
          nbits = 0;
        end
      end
      sck_prev = sck;
      if (sck && ss) sck_bad++;
      if (wr_ready && (sck || ss)) fetch_bad++;
      if (is_wr && idx == stall_at && wr_ready && !wr_valid) stall_cnt++;
      if (done && busy_first >= 0) begin
        done_n = n;
        done_busy = busy;
        break;
      end

      @(posedge clk); #1;
      if (n == 0) req = 1'b0;
      if (poke_busy && n == 20) begin req = 1'b1; req_cmd = 2'd1; end
      if (poke_busy && n == 21) req = 1'b0;
      if (hs) begin
        idx++;
        if (idx < LB) wr_data = payload[idx];
        if (idx == stall_at || idx >= LB) wr_valid = 1'b0;
      end
      if (is_wr && idx == stall_at && !wr_valid && stall_cnt >= stall_len) wr_valid = 1'b1;
      if (chain_next && done) begin
        req = 1'b1; req_cmd = 2'(next_cmd); req_line = 3'(next_line);
      end
      if (rst_at > 0 && hs_cnt >= rst_at) begin
        hs_wait++;
        if (hs_wait == 6) begin
          aborted = 1'b1;
          break;
        end
      end
    end
    wr_valid = 1'b0;

    if (aborted) begin
      // Mid-payload reset: outputs must return to idle without a clock edge.
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_ss", ss, 1'b1);
      checkOutput("rst_sck", sck, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_wr_ready", wr_ready, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_rx_bytes", rx_q.size(), rst_at);
      for (int i = 0; i < rst_at && i < rx_q.size(); i++)
        checkOutput($sformatf("rst_byte%0d", i), rx_q[i], exp_q[i]);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ss", ss, 1'b1);
      checkOutput("post_rst_busy", busy, 1'b0);
      return;
    end

    checkOutput("done_seen", (done_n >= 0), 1'b1);
    if (done_n < 0) return;
    checkOutput("busy_start", busy_first, 1);
    checkOutput("ss_low", ss_low, exp_ss);
    checkOutput("done_offset", done_n - busy_first, exp_ss + 2 * C);
    checkOutput("busy_cycles", busy_cnt, exp_ss + 2 * C);
    checkOutput("busy_at_done", done_busy, 1'b0);
    checkOutput("handshakes", hs_cnt, is_wr ? LB : 0);
    checkOutput("sck_outside_ss", sck_bad, 0);
    checkOutput("fetch_sck_ss", fetch_bad, 0);
    checkOutput("partial_bits", nbits, 0);
    checkOutput("rx_bytes", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      checkOutput($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
  endtask

  // A reserved command must produce no bus activity, busy or done.
  task automatic reservedReq();
    int busy_seen, ss_seen, done_seen;
    busy_seen = 0; ss_seen = 0; done_seen = 0;
    @(posedge clk); #1;
    req = 1'b1; req_cmd = 2'd3; req_line = 3'($urandom_range(0, 7));
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    repeat (8 * C) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (!ss) ss_seen++;
      if (done) done_seen++;
    end
    checkOutput("reserved_busy", busy_seen, 0);
    checkOutput("reserved_ss", ss_seen, 0);
    checkOutput("reserved_done", done_seen, 0);
  endtask

  initial begin
    int c;
    $display("[TB] start, CLK_DIV=%0d LINE_BYTES=%0d", C, LB);

    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_ss", ss, 1'b1);
    checkOutput("reset_sck", sck, 1'b0);
    checkOutput("reset_sdi", sdi, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_wr_ready", wr_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < LB; i++) payload[i] = 8'($urandom);

    $display("[TB] enable");
    applyStimulus(1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] disable then reserved");
    applyStimulus(0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    reservedReq();

    $display("[TB] write line 5, index data");
    for (int i = 0; i < LB; i++) payload[i] = 8'(i);
    applyStimulus(2, 5, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] write random line, random data, 50-cycle stall before byte 10");
    for (int i = 0; i < LB; i++) payload[i] = 8'($urandom);
    applyStimulus(2, int'($urandom_range(0, 7)), 10, 50, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] request while busy, then request in the done cycle");
    c = int'($urandom_range(0, 1));
    applyStimulus(0, 0, -1, 0, 1'b0, 1'b1, 1'b1, c, 0, 0);
    applyStimulus(c, 0, -1, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] reset during payload byte 3");
    for (int i = 0; i < LB; i++) payload[i] = 8'($urandom);
    applyStimulus(2, int'($urandom_range(0, 7)), -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 4);
    applyStimulus(1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] random enable/disable");
    for (int t = 0; t < 3; t++)
      applyStimulus(int'($urandom_range(0, 1)), 0, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
